// File: rtl/if_prefetch_pkg.sv
// ----------------------------------------------------------------------------
// if_prefetch_pkg
// Shared constants for the instruction-fetch front end: default widths,
// default FIFO depth and the default reset PC, plus a helper that sizes the
// occupancy / in-flight counters.
// ----------------------------------------------------------------------------
package if_prefetch_pkg;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_INST_W   = 32;
  localparam int unsigned DEF_DEPTH    = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  // Counters must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// DEPTH x WIDTH synchronous FIFO with first-word fall-through read, a
// single-cycle flush and an occupancy output.
//
// Ports
//   clk        clock
//   rst        asynchronous active-low reset (pointers and count only)
//   flush      empty the FIFO on the next edge; wins over push and pop
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        advance the head (ignored when empty)
//   head_valid FIFO not empty
//   head_data  current head entry, zero when empty
//   count      number of valid entries, 0..DEPTH
// ----------------------------------------------------------------------------
module fetch_fifo
  import if_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned WIDTH = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic                           head_valid,
  output logic [WIDTH-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign head_valid = (count != '0);
  assign do_push    = push && !flush;
  assign do_pop     = pop && head_valid && !flush;

  // Gating by head_valid keeps the outputs at zero while empty, including
  // during reset, without having to reset the storage array.
  assign head_data  = head_valid ? storage[rd_ptr] : '0;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_prefetch.sv
// ----------------------------------------------------------------------------
// if_prefetch
// Instruction-fetch front end. Issues in-order fetch requests to a
// variable-latency instruction memory, buffers returned instructions tagged
// with their PC in a DEPTH-entry fall-through FIFO and presents the head to
// the IF/ID boundary. A branch redirect flushes the FIFO, restarts fetch at
// the target and discards every response still in flight.
//
// Ports
//   clk        clock
//   rst        asynchronous active-low reset
//   stall      hold the head (not consumed)
//   br         redirect from ID
//   br_addr    redirect target
//   mem_req    fetch request valid
//   mem_addr   fetch address
//   mem_gnt    request accepted this cycle
//   mem_rvalid response valid (in request order)
//   mem_rdata  response instruction
//   id_valid   head valid
//   id_pc      head PC
//   id_inst    head instruction
// ----------------------------------------------------------------------------
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned INST_W   = DEF_INST_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INST_W / 8);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  outst;
  logic [CNT_W-1:0]  drop;
  logic [CNT_W-1:0]  outst_dec;
  logic [CNT_W:0]    inflight;
  logic              fire;
  logic              keep;
  logic              pop;

  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

  // Buffered plus in-flight instructions never exceed DEPTH, so every
  // response always has a free FIFO slot waiting for it.
  assign inflight  = {1'b0, cnt} + {1'b0, outst};
  assign mem_req   = rst && !br && (inflight < (CNT_W+1)'(DEPTH));
  assign mem_addr  = fetch_pc;
  assign fire      = mem_req && mem_gnt;

  // A response is kept only when no stale responses remain ahead of it and
  // no redirect is happening this cycle.
  assign keep      = mem_rvalid && (drop == '0) && !br;
  assign pop       = id_valid && !stall && !br;
  assign outst_dec = outst - CNT_W'(mem_rvalid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      outst    <= '0;
      drop     <= '0;
    end else begin
      // fire is forced low by br, so this also covers the redirect cycle.
      outst <= outst_dec + CNT_W'(fire);
      if (br) begin
        fetch_pc <= br_addr;
        resp_pc  <= br_addr;
        // Everything still outstanding after this cycle's response is stale.
        drop     <= outst_dec;
      end else begin
        if (fire) fetch_pc <= pc_next(fetch_pc);
        if (keep) resp_pc  <= pc_next(resp_pc);
        if (mem_rvalid && (drop != '0)) drop <= drop - CNT_W'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + INST_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (br),
    .push       (keep),
    .push_data  ({resp_pc, mem_rdata}),
    .pop        (pop),
    .head_valid (id_valid),
    .head_data  ({id_pc, id_inst}),
    .count      (cnt)
  );

endmodule

// File: tb/tb_if_prefetch.sv
module tb_if_prefetch;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              br;
  logic [ADDR_W-1:0] br_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [INST_W-1:0] mem_rdata;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;

  int tests_run    = 0;
  int tests_failed = 0;

  int cyc      = 0;
  int gnt_mode = 1;   // 0 never, 1 always, 2 random
  int lat_min  = 1;
  int lat_max  = 1;
  int grants   = 0;
  logic [ADDR_W-1:0] q_addr[$];
  int                q_rdy[$];

  always #5 clk = ~clk;

  if_prefetch #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br         (br),
    .br_addr    (br_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_inst    (id_inst)
  );

  function automatic logic [INST_W-1:0] inst_of(input logic [ADDR_W-1:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic mem_reset();
    q_addr.delete();
    q_rdy.delete();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  // One clock cycle: sample the handshake at the falling edge, let the DUT
  // clock, then update the memory model and drive the next cycle's inputs.
  task automatic tick();
    logic              fired;
    logic              resp;
    logic [ADDR_W-1:0] a;
    int                lat;
    @(negedge clk);
    fired = rst && mem_req && mem_gnt;
    resp  = mem_rvalid;
    a     = mem_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      mem_reset();
    end else begin
      if (resp && q_addr.size() > 0) begin
        void'(q_addr.pop_front());
        void'(q_rdy.pop_front());
      end
      if (fired) begin
        grants++;
        lat = int'($urandom_range(lat_max, lat_min));
        q_addr.push_back(a);
        q_rdy.push_back(cyc + lat - 1);
      end
    end
    mem_gnt = (gnt_mode == 1) ? 1'b1 :
              (gnt_mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
    if (q_addr.size() > 0 && q_rdy[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = inst_of(q_addr[0]);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; br = 1'b0; br_addr = '0;
    gnt_mode = 1; mem_gnt = 1'b1; lat_min = 1; lat_max = 1;
    mem_reset();
    tick(); tick();
    tests_run++;
    if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    tests_run++;
    if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
    tests_run++;
    if (id_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_id_pc got %h want 0", id_pc); end
    tests_run++;
    if (id_inst !== 32'h0) begin tests_failed++; $display("FAIL reset_id_inst got %h want 0", id_inst); end
  endtask

  task automatic test_stream();
    logic [ADDR_W-1:0] exp;
    rst = 1'b1;
    #1;
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      tests_failed++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr);
    end
    tick();
    tests_run++;
    if (id_valid !== 1'b0 || mem_addr !== 32'h4) begin
      tests_failed++; $display("FAIL stream_c1 got valid=%b addr=%h want valid=0 addr=4", id_valid, mem_addr);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      exp = ADDR_W'(4 * k);
      tests_run++;
      if (id_valid !== 1'b1 || id_pc !== exp || id_inst !== inst_of(exp)) begin
        tests_failed++;
        $display("FAIL stream_pc got valid=%b pc=%h inst=%h want pc=%h inst=%h", id_valid, id_pc, id_inst, exp, inst_of(exp));
      end
    end
  endtask

  // Head is 0x1C with 0x20 in flight; stalling lets 0x24 and 0x28 be granted,
  // after which the FIFO holds 0x1C..0x28 and fetch waits at 0x2C.
  task automatic test_stall();
    logic [ADDR_W-1:0] exp;
    stall = 1'b1;
    grants = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      tests_run++;
      if (id_valid !== 1'b1 || id_pc !== 32'h1C) begin
        tests_failed++; $display("FAIL stall_hold got valid=%b pc=%h want pc=1c", id_valid, id_pc);
      end
    end
    tests_run++;
    if (grants !== 2) begin tests_failed++; $display("FAIL stall_grants got %0d want 2", grants); end
    tests_run++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h2C) begin
      tests_failed++; $display("FAIL stall_full got req=%b addr=%h want req=0 addr=2c", mem_req, mem_addr);
    end
    stall = 1'b0;
    #1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp = 32'h1C + ADDR_W'(4 * i);
      tests_run++;
      if (id_valid !== 1'b1 || id_pc !== exp || id_inst !== inst_of(exp)) begin
        tests_failed++;
        $display("FAIL stall_resume got valid=%b pc=%h inst=%h want pc=%h", id_valid, id_pc, id_inst, exp);
      end
    end
  endtask

  task automatic test_redirect_drop();
    rst = 1'b0; stall = 1'b0; br = 1'b0;
    mem_reset();
    lat_min = 3; lat_max = 3; gnt_mode = 1;
    tick();
    rst = 1'b1;
    tick(); tick();
    // Requests for 0x0 and 0x4 are outstanding and not yet answered.
    br = 1'b1; br_addr = 32'h100;
    #1;
    tests_run++;
    if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL redir_req_low got %b want 0", mem_req); end
    tick();
    br = 1'b0;
    #1;
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      tests_failed++; $display("FAIL redir_first_req got req=%b addr=%h want req=1 addr=100", mem_req, mem_addr);
    end
    tests_run++;
    if (dut.drop !== 3'd2) begin tests_failed++; $display("FAIL redir_drop2 got %0d want 2", dut.drop); end
    tick();
    tests_run++;
    if (dut.drop !== 3'd1 || id_valid !== 1'b0) begin
      tests_failed++; $display("FAIL redir_drop1 got drop=%0d valid=%b want drop=1 valid=0", dut.drop, id_valid);
    end
    tick();
    tests_run++;
    if (dut.drop !== 3'd0 || id_valid !== 1'b0) begin
      tests_failed++; $display("FAIL redir_drop0 got drop=%0d valid=%b want drop=0 valid=0", dut.drop, id_valid);
    end
    tick();
    tests_run++;
    if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_wait got valid=%b want 0", id_valid); end
    tick();
    tests_run++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== inst_of(32'h100)) begin
      tests_failed++;
      $display("FAIL redir_target got valid=%b pc=%h inst=%h want pc=100 inst=%h", id_valid, id_pc, id_inst, inst_of(32'h100));
    end
  endtask

  task automatic test_br_same_cycle();
    rst = 1'b0; br = 1'b0;
    mem_reset();
    lat_min = 1; lat_max = 1; gnt_mode = 1;
    tick();
    rst = 1'b1;
    tick(); tick();
    // Head 0x0 would pop and the response for 0x4 is arriving this cycle.
    tests_run++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || mem_rvalid !== 1'b1) begin
      tests_failed++; $display("FAIL brsame_setup got valid=%b pc=%h want valid=1 pc=0", id_valid, id_pc);
    end
    br = 1'b1; br_addr = 32'h200;
    #1;
    tests_run++;
    if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL brsame_req_low got %b want 0", mem_req); end
    tick();
    br = 1'b0;
    #1;
    tests_run++;
    if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL brsame_empty got valid=%b want 0", id_valid); end
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200 || dut.drop !== 3'd0) begin
      tests_failed++; $display("FAIL brsame_req got req=%b addr=%h drop=%0d want req=1 addr=200 drop=0", mem_req, mem_addr, dut.drop);
    end
    tick();
    tests_run++;
    if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL brsame_wait got valid=%b want 0", id_valid); end
    tick();
    tests_run++;
    if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_inst !== inst_of(32'h200)) begin
      tests_failed++; $display("FAIL brsame_target got valid=%b pc=%h inst=%h want pc=200", id_valid, id_pc, id_inst);
    end
  endtask

  task automatic test_wrap();
    br = 1'b1; br_addr = 32'hFFFF_FFF8;
    tick();
    br = 1'b0;
    #1;
    tests_run++;
    if (mem_addr !== 32'hFFFF_FFF8) begin tests_failed++; $display("FAIL wrap_a0 got %h want fffffff8", mem_addr); end
    tick();
    tests_run++;
    if (mem_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_a1 got %h want fffffffc", mem_addr); end
    tick();
    tests_run++;
    if (mem_addr !== 32'h0 || id_pc !== 32'hFFFF_FFF8) begin
      tests_failed++; $display("FAIL wrap_a2 got addr=%h pc=%h want addr=0 pc=fffffff8", mem_addr, id_pc);
    end
    tick();
    tests_run++;
    if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC) begin
      tests_failed++; $display("FAIL wrap_pc1 got valid=%b pc=%h want fffffffc", id_valid, id_pc);
    end
    tick();
    tests_run++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== inst_of(32'h0)) begin
      tests_failed++; $display("FAIL wrap_pc2 got valid=%b pc=%h inst=%h want pc=0", id_valid, id_pc, id_inst);
    end
  endtask

  task automatic test_async_reset();
    rst = 1'b0;
    #1;
    tests_run++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0 || mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_rst got valid=%b pc=%h inst=%h req=%b want all 0", id_valid, id_pc, id_inst, mem_req);
    end
    mem_reset();
    tick(); tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      tests_failed++; $display("FAIL rst_restart got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr);
    end
    tick(); tick();
    tests_run++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== inst_of(32'h0)) begin
      tests_failed++; $display("FAIL rst_first_inst got valid=%b pc=%h inst=%h want pc=0", id_valid, id_pc, id_inst);
    end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] exp;
    int n;
    int cycles;
    rst = 1'b0; br = 1'b0; stall = 1'b0;
    mem_reset();
    lat_min = 1; lat_max = 5; gnt_mode = 2;
    tick();
    rst = 1'b1;
    exp = '0; n = 0; cycles = 0;
    while (n < 1000 && cycles < 20000) begin
      stall = ($urandom_range(0, 3) == 0);
      #1;
      if (id_valid && !stall) begin
        tests_run++;
        if (id_pc !== exp || id_inst !== inst_of(exp)) begin
          tests_failed++; $display("FAIL rand_seq got pc=%h inst=%h want pc=%h", id_pc, id_inst, exp);
        end
        exp = exp + 32'h4;
        n++;
      end
      tests_run++;
      if (int'(dut.cnt) > DEPTH || int'(dut.outst) > DEPTH) begin
        tests_failed++; $display("FAIL rand_bounds got cnt=%0d outst=%0d want <= %0d", dut.cnt, dut.outst, DEPTH);
      end
      tick();
      cycles++;
    end
    stall = 1'b0;
    tests_run++;
    if (n < 1000) begin tests_failed++; $display("FAIL rand_timeout got %0d instructions want 1000", n); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_br_same_cycle();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
